// File: rtl/orient_hist32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sift_orient_pkg                                           |
// | Purpose  : Shared constants, state encoding and width helpers for    |
// |            the orientation histogram blocks.                         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sift_orient_pkg;

    localparam int NUM_BINS = 32;
    localparam int DIR_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // One guard bit above the wider operand exposes the carry for saturation.
    function automatic int sat_sum_w(input int acc_w, input int mag_w);
        return ((acc_w > mag_w) ? acc_w : mag_w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/orient_hist32_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : orient_hist32_if                                          |
// | Purpose  : Sample-in and peak-out handshakes of the orientation      |
// |            histogram.                                                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface orient_hist32_if #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_dir;
    logic [MAG_W-1:0] in_mag;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_bin;
    logic [ACC_W-1:0] out_peak;

    modport master (
        output in_valid, in_dir, in_mag, in_last, out_ready,
        input  in_ready, out_valid, out_bin, out_peak
    );

    modport slave (
        input  in_valid, in_dir, in_mag, in_last, out_ready,
        output in_ready, out_valid, out_bin, out_peak
    );
endinterface
`default_nettype wire

// File: rtl/orient_hist32_peak_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : orient_peak_scan                                          |
// | Purpose  : Sequential argmax, one entry per enabled cycle, lowest    |
// |            index wins ties. Results hold while not enabled.          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module orient_peak_scan #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_en,
    input  wire logic [IDX_W-1:0]  i_idx,
    input  wire logic [DATA_W-1:0] i_data,
    output logic      [IDX_W-1:0]  o_max_idx,
    output logic      [DATA_W-1:0] o_max_val
);

    logic [IDX_W-1:0]  r_max_idx;
    logic [DATA_W-1:0] r_max_val;
    logic              w_take;

    // Index 0 seeds the running max; afterwards only a strictly larger value replaces it.
    assign w_take = (i_idx == '0) || (i_data > r_max_val);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max_idx <= '0;
            r_max_val <= '0;
        end else if (i_en && w_take) begin
            r_max_idx <= i_idx;
            r_max_val <= i_data;
        end
    end

    assign o_max_idx = r_max_idx;
    assign o_max_val = r_max_val;

endmodule
`default_nettype wire

// File: rtl/orient_hist32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : orient_hist32                                             |
// | Purpose  : Per-bin magnitude histogram over one keypoint window,     |
// |            followed by a 32-cycle dominant-orientation scan.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module orient_hist32
    import sift_orient_pkg::*;
#(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      start,
    output logic           busy,
    orient_hist32_if.slave bus
);

    localparam int SUM_W = sat_sum_w(ACC_W, MAG_W);
    localparam logic [SUM_W-1:0] c_acc_max = SUM_W'({ACC_W{1'b1}});

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  r_bins [NUM_BINS];
    logic [DIR_W-1:0]  r_idx;
    logic              w_accept;
    logic              w_clear;
    logic              w_scan_done;
    logic [SUM_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_bin_new;
    logic [ACC_W-1:0]  w_scan_data;
    logic [DIR_W-1:0]  w_max_idx;
    logic [ACC_W-1:0]  w_max_val;

    assign w_accept    = bus.in_valid && (r_state == ST_ACCUM);
    assign w_clear     = start && (r_state == ST_IDLE);
    assign w_scan_done = (r_state == ST_SCAN) && (r_idx == DIR_W'(NUM_BINS - 1));

    // Widened add so the overflow is visible; all-ones then stays all-ones.
    assign w_sum     = SUM_W'(r_bins[bus.in_dir]) + SUM_W'(bus.in_mag);
    assign w_bin_new = (w_sum > c_acc_max) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)                   w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_accept && bus.in_last) w_state_nxt = ST_SCAN;
            ST_SCAN:  if (w_scan_done)             w_state_nxt = ST_OUT;
            ST_OUT:   if (bus.out_ready)           w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (w_accept) begin
            r_bins[bus.in_dir] <= w_bin_new;
        end
    end

    // Index wraps back to 0 after 31, leaving it ready for the next window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (r_state == ST_SCAN) begin
            r_idx <= r_idx + DIR_W'(1);
        end else begin
            r_idx <= '0;
        end
    end

    assign w_scan_data = r_bins[r_idx];

    orient_peak_scan #(
        .DATA_W (ACC_W),
        .IDX_W  (DIR_W)
    ) u_peak_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == ST_SCAN),
        .i_idx     (r_idx),
        .i_data    (w_scan_data),
        .o_max_idx (w_max_idx),
        .o_max_val (w_max_val)
    );

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_OUT);
    assign bus.out_bin   = w_max_idx;
    assign bus.out_peak  = w_max_val;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_orient_hist32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_orient_hist32                                          |
// | Purpose  : Directed vector bench for orient_hist32.                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_orient_hist32;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    orient_hist32_if #(.MAG_W(8), .ACC_W(16)) bus ();

    orient_hist32 #(.MAG_W(8), .ACC_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      n;
        logic [2:0][4:0] dir;
        logic [2:0][7:0] mag;
        logic [4:0]      exp_bin;
        logic [15:0]     exp_peak;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int n, input int d0, input int m0, input int d1,
                                input int m1, input int d2, input int m2,
                                input int eb, input int ep);
        vec_t v;
        v.n        = 2'(n);
        v.dir[0]   = 5'(d0);
        v.mag[0]   = 8'(m0);
        v.dir[1]   = 5'(d1);
        v.mag[1]   = 8'(m1);
        v.dir[2]   = 5'(d2);
        v.mag[2]   = 8'(m2);
        v.exp_bin  = 5'(eb);
        v.exp_peak = 16'(ep);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("in_ready_after_start", int'(bus.in_ready), 1);
    endtask

    task automatic send(input int d, input int m, input bit last);
        bus.in_valid = 1'b1;
        bus.in_dir   = 5'(d);
        bus.in_mag   = 8'(m);
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called one step after the edge that took the last sample.
    task automatic wait_out(input int eb, input int ep, input bit noise);
        int cnt;
        check("in_ready_drop", int'(bus.in_ready), 0);
        cnt = 1;
        while (!bus.out_valid && cnt < 200) begin
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.in_dir   = 5'd5;
                bus.in_mag   = 8'd99;
                bus.in_last  = 1'b1;
            end
            tick();
            cnt++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("latency", cnt, 33);
        check("out_bin", int'(bus.out_bin), eb);
        check("out_peak", int'(bus.out_peak), ep);
    endtask

    task automatic accept(input int eb, input int ep);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", int'(bus.out_valid), 0);
        check("busy_idle", int'(busy), 0);
        check("out_bin_hold", int'(bus.out_bin), eb);
        check("out_peak_hold", int'(bus.out_peak), ep);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_dir    = '0;
        bus.in_mag    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = mk(3,  7,  20,  7,  30, 12,  40,  7,  50);
        vecs[1] = mk(2, 31,  25,  4,  25,  0,   0,  4,  25);
        vecs[2] = mk(1,  3,  10,  0,   0,  0,   0,  3,  10);
        vecs[3] = mk(2,  0,   5, 31,   6,  0,   0, 31,   6);
        vecs[4] = mk(3, 10, 200, 10, 200, 11, 255, 10, 400);
        vecs[5] = mk(3,  1,   0, 30,   1,  1,   0, 30,   1);

        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_bin", int'(bus.out_bin), 0);
        check("rst_out_peak", int'(bus.out_peak), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            do_start();
            for (int s = 0; s < int'(vecs[v].n); s++) begin
                send(int'(vecs[v].dir[s]), int'(vecs[v].mag[s]), s == int'(vecs[v].n) - 1);
            end
            wait_out(int'(vecs[v].exp_bin), int'(vecs[v].exp_peak), 1'b0);
            accept(int'(vecs[v].exp_bin), int'(vecs[v].exp_peak));
        end

        // Reset in the middle of a window discards everything collected so far.
        do_start();
        for (int s = 0; s < 5; s++) send(3, 100 + s, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        check("midrst_out_bin", int'(bus.out_bin), 0);
        check("midrst_out_peak", int'(bus.out_peak), 0);
        do_start();
        send(3, 10, 1'b1);
        wait_out(3, 10, 1'b0);
        accept(3, 10);

        // Saturation: 301 * 255 far exceeds the 16-bit range.
        do_start();
        for (int s = 0; s < 300; s++) send(0, 255, 1'b0);
        send(0, 255, 1'b1);
        wait_out(0, 16'hFFFF, 1'b0);
        accept(0, 16'hFFFF);

        // All-zero window held under backpressure while start is asserted.
        do_start();
        send(9, 0, 1'b1);
        wait_out(0, 0, 1'b0);
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_out_bin", int'(bus.out_bin), 0);
            check("bp_out_peak", int'(bus.out_peak), 0);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        start = 1'b0;
        accept(0, 0);
        tick();
        check("bp_stay_idle", int'(busy), 0);

        // Samples offered in IDLE and SCAN must not land in the histogram.
        bus.in_valid = 1'b1;
        bus.in_dir   = 5'd5;
        bus.in_mag   = 8'd99;
        bus.in_last  = 1'b1;
        tick();
        tick();
        check("idle_in_valid_busy", int'(busy), 0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        do_start();
        send(2, 1, 1'b1);
        wait_out(2, 1, 1'b1);
        accept(2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/orient_hist32.md
Name: orient_hist32

Overview:
- Consumer of the 5-bit orientation bins (0..31) produced by the distributed-ROM direction lookups.
- Accumulates gradient magnitude per bin over one keypoint window, then sequentially scans the 32 bins for the dominant orientation.
- Returns the peak bin and its weight to the descriptor stage through a valid/ready output.
- Sits between the gradient/direction lookup path and the descriptor rotation logic.

Parameters:
- MAG_W, 8, width of input gradient magnitude
- ACC_W, 16, width of each histogram bin accumulator; saturating

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a new window; sampled only in IDLE
- in_valid  in  1  sample valid
- in_ready  out  1  high only in ACCUM
- in_dir  in  5  orientation bin 0..31
- in_mag  in  MAG_W  magnitude weight, unsigned
- in_last  in  1  marks final sample of window; qualified by in_valid&in_ready
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accept
- out_bin  out  5  peak bin index
- out_peak  out  ACC_W  peak bin weight
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all 32 bins=0; in_ready=0, out_valid=0, out_bin=0, out_peak=0, busy=0; scan index=0. Reset mid-operation aborts the window; partial data is discarded.
- States: IDLE, ACCUM, SCAN, OUT.
- IDLE: start=1 clears all 32 bins in a single edge and enters ACCUM. in_ready is high from the next cycle. start in any other state is ignored.
- ACCUM: each accepted sample does bin[in_dir] <= min(bin[in_dir]+in_mag, 2^ACC_W-1).
  - Saturation is sticky at all-ones.
  - Accepts one sample per cycle with no bubbles; back-to-back samples to the same bin both count.
  - An accepted sample with in_last=1 is accumulated first; the state then moves to SCAN and in_ready drops the next cycle.
- SCAN: 32 cycles, index 0..31, one bin per cycle.
  - Running max is compared with strict greater-than, so on ties the lowest bin index wins.
  - Running max is initialised to bin 0 at index 0.
  - After index 31, enter OUT.
- Latency: last sample accepted in cycle T, SCAN occupies T+1..T+32, out_valid=1 from T+33.
- OUT:
  - out_valid=1; out_bin and out_peak are stable while out_valid&!out_ready.
  - On out_valid&out_ready, go to IDLE and drop out_valid the next cycle.
  - out_bin/out_peak hold their last values in IDLE.
- All-zero window: out_bin=0, out_peak=0.
- Zero-magnitude samples are accepted and leave the bins unchanged.
- in_valid outside ACCUM: not accepted, no effect.
- in_dir is full 5-bit range; wrap-around between bin 31 and bin 0 is not smoothed here (downstream responsibility).

Decomposition:
- Shared package sift_orient_pkg holds:
  - NUM_BINS=32, DIR_W=5
  - state encoding constants for IDLE/ACCUM/SCAN/OUT
  - saturating-add width rule used by other histogram blocks
- One natural sub-module: orient_peak_scan, the sequential 32-entry argmax with lowest-index tie-break. It is reused for the descriptor's secondary-peak search.
- Bin storage stays as a register array in the top module; 32xACC_W is small enough for flops and needs a single-cycle clear.

Test Plan:
- Reset mid-ACCUM after 5 samples, then start plus one sample (dir=3, mag=10, last) -> out_bin=3, out_peak=10; no residue from the aborted window.
- start; samples (dir=7, mag=20), (dir=7, mag=30), (dir=12, mag=40, last) back-to-back -> out_valid exactly 33 cycles after last is accepted; out_bin=7, out_peak=50.
- Tie: (dir=31, mag=25), (dir=4, mag=25, last) -> out_bin=4, out_peak=25.
- Saturation with MAG_W=8, ACC_W=16: 300 samples to dir=0 with mag=255, then last -> out_peak=16'hFFFF, out_bin=0, no wrap.
- All-zero window: start, one sample (dir=9, mag=0, last) -> out_bin=0, out_peak=0. Backpressure: out_ready=0 for 10 cycles -> out_valid and outputs stable, in_ready=0, start ignored. Release -> IDLE next cycle.
- in_valid pulsed in IDLE and SCAN with dir=5, mag=99 -> ignored. A subsequent window containing only (dir=2, mag=1, last) returns out_bin=2, out_peak=1.
